// File: rtl/lane_data_pkg.sv
// Shared constants for the lane data generator: default sizing, end-of-range
// mode encoding and the lane-index width helper.
package lane_data_pkg;

  localparam int DEF_LANES = 4;
  localparam int DEF_DW    = 8;
  localparam int DEF_STEP  = 4;
  localparam int DEF_LIMIT = 16;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  // Width of a lane index; a single lane still gets a 1-bit index.
  function automatic int lane_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_lane_arbiter.sv
// Round-robin selector over the pending-lane vector. Scans from the lane
// after the last one served; right after reset (first=1) it scans from lane 0.
module rr_lane_arbiter
  import lane_data_pkg::*;
#(
  parameter  int LANES = DEF_LANES,
  localparam int IW    = lane_idx_w(LANES)
) (
  input  logic [LANES-1:0] pending,
  input  logic [IW-1:0]    last,
  input  logic             first,
  output logic [IW-1:0]    grant,
  output logic             any
);

  int          start;
  int          idx_i;
  logic [IW-1:0] idx;
  logic        found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx_i = 0;
    idx   = '0;
    start = first ? 0 : int'(last) + 1;
    if (start >= LANES) start = 0;
    for (int k = 0; k < LANES; k++) begin
      idx_i = start + k;
      if (idx_i >= LANES) idx_i = idx_i - LANES;
      idx = IW'(idx_i);
      if (!found && pending[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
    any = |pending;
  end

endmodule

// File: rtl/lane_data_generator.sv
// Multi-lane stepping counter generator with wrap/saturate end-of-range
// behaviour and a coalesced, round-robin event record output.
module lane_data_generator
  import lane_data_pkg::*;
#(
  parameter  int LANES = DEF_LANES,
  parameter  int DW    = DEF_DW,
  parameter  int STEP  = DEF_STEP,
  parameter  int LIMIT = DEF_LIMIT,
  localparam int IW    = lane_idx_w(LANES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic [LANES-1:0]    map,
  input  logic [LANES-1:0]    clr,
  input  logic                mode,
  output logic                data_en,
  output logic [LANES*DW-1:0] data,
  output logic [LANES-1:0]    wrap,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IW-1:0]       out_lane,
  output logic [DW-1:0]       out_data
);

  localparam logic [DW:0] STEP_X  = (DW+1)'(STEP);
  localparam logic [DW:0] LIMIT_X = (DW+1)'(LIMIT);

  logic [LANES*DW-1:0] data_nxt;
  logic [LANES-1:0]    wrap_nxt;
  logic [LANES-1:0]    changed;
  logic [DW-1:0]       lane_val [LANES];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DW-1:0] cur;
    logic [DW-1:0] nxt;
    logic [DW:0]   sum;
    logic          adv;
    logic          at_limit;
    logic          wrap_i;

    assign cur      = data[i*DW +: DW];
    assign adv      = data_en & tick & map[i] & ~clr[i];
    assign sum      = {1'b0, cur} + STEP_X;
    assign at_limit = ({1'b0, cur} >= LIMIT_X);

    // Clear wins over advance; at the limit, saturate mode simply holds.
    always_comb begin
      nxt    = cur;
      wrap_i = 1'b0;
      if (clr[i]) begin
        nxt = '0;
      end else if (adv) begin
        if (!at_limit) begin
          nxt = (sum > LIMIT_X) ? LIMIT_X[DW-1:0] : sum[DW-1:0];
        end else if (mode_e'(mode) == MODE_WRAP) begin
          nxt    = '0;
          wrap_i = 1'b1;
        end
      end
    end

    assign data_nxt[i*DW +: DW] = nxt;
    assign wrap_nxt[i]          = wrap_i;
    assign changed[i]           = (nxt != cur);
    assign lane_val[i]          = cur;
  end

  logic [LANES-1:0] pending;
  logic [LANES-1:0] pending_nxt;
  logic [LANES-1:0] served;
  logic [IW-1:0]    last_q;
  logic             first_q;
  logic [IW-1:0]    grant;
  logic             any_pending;
  logic             load;

  rr_lane_arbiter #(.LANES(LANES)) u_arb (
    .pending (pending),
    .last    (last_q),
    .first   (first_q),
    .grant   (grant),
    .any     (any_pending)
  );

  // Handshake: a record transfers on a rising edge where out_valid and
  // out_ready are both 1; while out_valid=1 and out_ready=0 the record holds.
  // The register reloads whenever it is empty or transferring this edge.
  assign load        = any_pending & (~out_valid | out_ready);
  assign served      = load ? (LANES'(1) << grant) : '0;
  assign pending_nxt = (pending & ~served) | changed;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_en   <= 1'b0;
      data      <= '0;
      wrap      <= '0;
      pending   <= '0;
      out_valid <= 1'b0;
      out_lane  <= '0;
      out_data  <= '0;
      last_q    <= '0;
      first_q   <= 1'b1;
    end else begin
      data_en <= 1'b1;
      data    <= data_nxt;
      wrap    <= wrap_nxt;
      pending <= pending_nxt;
      if (load) begin
        out_valid <= 1'b1;
        out_lane  <= grant;
        out_data  <= lane_val[grant];
        last_q    <= grant;
        first_q   <= 1'b0;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lane_data_generator.sv
// Directed bench for lane_data_generator: lane stepping, wrap/saturate,
// round-robin records, back-pressure, clear and reset-during-handshake.
module tb_lane_data_generator;
  import lane_data_pkg::*;

  localparam int LANES = 4;
  localparam int DW    = 8;
  localparam int IW    = 2;
  localparam int RW    = IW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic                tick = 1'b0;
  logic [LANES-1:0]    map = '0;
  logic [LANES-1:0]    clr = '0;
  logic                mode = 1'b0;
  logic                out_ready = 1'b1;

  logic                data_en, out_valid;
  logic [LANES*DW-1:0] data;
  logic [LANES-1:0]    wrap;
  logic [IW-1:0]       out_lane;
  logic [DW-1:0]       out_data;

  logic                data_en5, out_valid5;
  logic [LANES*DW-1:0] data5;
  logic [LANES-1:0]    wrap5;
  logic [IW-1:0]       out_lane5;
  logic [DW-1:0]       out_data5;

  lane_data_generator u_dut (
    .clk(clk), .reset(reset), .tick(tick), .map(map), .clr(clr), .mode(mode),
    .data_en(data_en), .data(data), .wrap(wrap), .out_valid(out_valid),
    .out_ready(out_ready), .out_lane(out_lane), .out_data(out_data)
  );

  lane_data_generator #(.STEP(5)) u_dut5 (
    .clk(clk), .reset(reset), .tick(tick), .map(map), .clr(clr), .mode(mode),
    .data_en(data_en5), .data(data5), .wrap(wrap5), .out_valid(out_valid5),
    .out_ready(out_ready), .out_lane(out_lane5), .out_data(out_data5)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [RW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [RW-1:0] rec(input int lane, input int val);
    return {IW'(lane), DW'(val)};
  endfunction

  // ---------------- monitor ----------------
  logic          stalled = 1'b0;
  logic [RW-1:0] held = '0;
  logic [RW-1:0] exp_rec;

  always @(negedge clk) begin
    if (reset) begin
      stalled <= 1'b0;
    end else begin
      if (stalled && out_valid)
        chk("stall_hold", 32'({out_lane, out_data}), 32'(held));
      stalled <= out_valid && !out_ready;
      held    <= {out_lane, out_data};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_record actual=lane%0d/0x%0h required=none at %0t",
                   out_lane, out_data, $time);
        end else begin
          exp_rec = exp_q.pop_front();
          chk("record", 32'({out_lane, out_data}), 32'(exp_rec));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick  = 1'b0;
    map   = '0;
    clr   = '0;
    step();
    step();
    chk("rst_data_en", 32'(data_en), 32'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_lane", 32'(out_lane), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    reset = 1'b0;
    step();
    chk("data_en_up", 32'(data_en), 32'd1);
  endtask

  // ---------------- directed tests ----------------
  int e4[5] = '{4, 8, 12, 16, 0};
  int e5[5] = '{5, 10, 15, 16, 0};
  int ew[5] = '{0, 0, 0, 0, 1};
  int es[6] = '{4, 8, 12, 16, 16, 16};

  initial begin
    // Wrap mode, lane 0 stepping, and the STEP=5 instance alongside.
    do_reset();
    mode = 1'b0;
    out_ready = 1'b1;
    exp_q.push_back(rec(0, 4));
    exp_q.push_back(rec(0, 8));
    exp_q.push_back(rec(0, 12));
    exp_q.push_back(rec(0, 16));
    exp_q.push_back(rec(0, 0));
    tick = 1'b1;
    map  = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("wrap_lane0", 32'(data[7:0]), e4[i]);
      chk("wrap_pulse0", 32'(wrap[0]), ew[i]);
      chk("step5_lane0", 32'(data5[7:0]), e5[i]);
      chk("step5_pulse0", 32'(wrap5[0]), ew[i]);
    end
    tick = 1'b0;
    map  = '0;
    step();
    chk("wrap_pulse_once", 32'(wrap[0]), 32'd0);
    idle(3);
    chk("wrap_q_empty", 32'(exp_q.size()), 32'd0);

    // Saturate mode: lane 0 sticks at 16, no wrap, no further record.
    do_reset();
    mode = 1'b1;
    exp_q.push_back(rec(0, 4));
    exp_q.push_back(rec(0, 8));
    exp_q.push_back(rec(0, 12));
    exp_q.push_back(rec(0, 16));
    tick = 1'b1;
    map  = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("sat_lane0", 32'(data[7:0]), es[i]);
      chk("sat_wrap", 32'(wrap), 32'd0);
    end
    tick = 1'b0;
    map  = '0;
    idle(3);
    chk("sat_idle_valid", 32'(out_valid), 32'd0);
    chk("sat_q_empty", 32'(exp_q.size()), 32'd0);
    mode = 1'b0;

    // All four lanes advance together; records drain 0,1,2,3 back to back.
    do_reset();
    out_ready = 1'b1;
    for (int l = 0; l < 4; l++) exp_q.push_back(rec(l, 4));
    tick = 1'b1;
    map  = 4'b1111;
    step();
    tick = 1'b0;
    map  = '0;
    chk("all_lanes", data, 32'h04040404);
    for (int l = 0; l < 4; l++) begin
      step();
      chk("rr_valid", 32'(out_valid), 32'd1);
      chk("rr_lane", 32'(out_lane), l);
    end
    step();
    chk("rr_drained", 32'(out_valid), 32'd0);
    idle(2);
    chk("rr_q_empty", 32'(exp_q.size()), 32'd0);

    // Back-pressure: lane 2 advances 3 times under a 5-cycle stall; coalesced.
    do_reset();
    out_ready = 1'b0;
    exp_q.push_back(rec(2, 4));
    exp_q.push_back(rec(2, 12));
    tick = 1'b1;
    map  = 4'b0100;
    idle(3);
    tick = 1'b0;
    map  = '0;
    chk("bp_lane2", 32'(data[23:16]), 32'd12);
    idle(2);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_hold_lane", 32'(out_lane), 32'd2);
    chk("bp_hold_data", 32'(out_data), 32'd4);
    out_ready = 1'b1;
    idle(3);
    chk("bp_drained", 32'(out_valid), 32'd0);
    chk("bp_q_empty", 32'(exp_q.size()), 32'd0);

    // Clear and advance on lane 1 in the same cycle: clear wins, no wrap.
    do_reset();
    out_ready = 1'b1;
    exp_q.push_back(rec(1, 4));
    exp_q.push_back(rec(1, 0));
    tick = 1'b1;
    map  = 4'b0010;
    step();
    chk("clr_pre", 32'(data[15:8]), 32'd4);
    clr = 4'b0010;
    step();
    clr  = '0;
    tick = 1'b0;
    map  = '0;
    chk("clr_lane1", 32'(data[15:8]), 32'd0);
    chk("clr_no_wrap", 32'(wrap), 32'd0);
    step();
    chk("clr_no_wrap_next", 32'(wrap), 32'd0);
    idle(3);
    chk("clr_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset while a record is held: it is dropped and nothing follows.
    out_ready = 1'b0;
    tick = 1'b1;
    map  = 4'b1111;
    step();
    tick = 1'b0;
    map  = '0;
    step();
    chk("mid_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    step();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", data, 32'd0);
    chk("mid_rst_en", 32'(data_en), 32'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    idle(6);
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    chk("post_rst_q_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lane_data_generator.md
LANE_DATA_GENERATOR -- requirements
Module: lane_data_generator

Interface
REQ-001 SHALL have parameters: LANES, default 4, number of independent lanes; DW, default 8, lane value width; STEP, default 4, per-advance increment; LIMIT, default 16, terminal lane value.
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 Port list:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- tick  in  1  global advance strobe
- map  in  LANES  per-lane advance enable
- clr  in  LANES  per-lane clear to 0
- mode  in  1  end-of-range behaviour: 0 = wrap, 1 = saturate
- data_en  out  1  generator running
- data  out  LANES*DW  lane values; lane i at bits [i*DW +: DW]
- wrap  out  LANES  one-cycle wrap pulse per lane
- out_valid  out  1  event record valid
- out_ready  in  1  consumer accepts record
- out_lane  out  max(1,clog2(LANES))  lane index of record
- out_data  out  DW  lane value captured in record

Function
REQ-004 SHALL drive data_en to 0 in reset and to 1 from the first clk edge after reset deasserts.
REQ-005 SHALL advance lane i only in a cycle where data_en=1, tick=1, map[i]=1 and clr[i]=0.
REQ-006 An advance with data_i < LIMIT SHALL set data_i to min(data_i+STEP, LIMIT), computed at DW+1 bits.
REQ-007 An advance with data_i >= LIMIT and mode=0 SHALL set data_i to 0 and assert wrap[i] for exactly the next cycle.
REQ-008 An advance with data_i >= LIMIT and mode=1 SHALL hold data_i at its current value, with no wrap pulse and no event.
REQ-009 clr[i]=1 SHALL set data_i to 0 on that edge, override any advance, and assert no wrap pulse.
REQ-010 Each lane SHALL update independently; simultaneous updates on all lanes in one cycle SHALL be supported.
REQ-011 Any update that changes data_i, whether advance, wrap or clear-from-nonzero, SHALL set pending[i].
REQ-012 Events SHALL be coalesced: at most one pending event per lane; the record reports the lane value at capture time.
REQ-013 Output register:
- when empty, or when out_valid and out_ready are both 1, it SHALL load the next pending lane;
- lane selection is round-robin, starting at the lane after the last one served, wrapping LANES-1 to 0;
- loading captures out_lane = i and out_data = data_i (the registered value) and clears pending[i].
REQ-014 A pending set and clear for the same lane in the same cycle SHALL resolve to set.
REQ-015 While out_valid=1 and out_ready=0, out_lane and out_data SHALL remain stable.
REQ-016 out_valid SHALL fall only after a handshake with no pending lanes left.
REQ-017 Latency: an update at edge N SHALL produce out_valid at edge N+1 when the output register is empty; sustained throughput is one record per cycle.
REQ-018 Parameter constraints: STEP >= 1; LIMIT < 2**DW; LIMIT >= STEP.

Reset
REQ-019 reset SHALL force all of the following to 0, with reset taking priority over all inputs:
- data_en, every data lane, wrap, pending, out_valid, out_lane, out_data;
- the round-robin pointer, so the first lane served after reset is lane 0.
REQ-020 A reset asserted mid-handshake SHALL drop the pending record; no record is emitted after reset deasserts until a new update occurs.

Structure
REQ-021 The default LIMIT and STEP, the mode encoding (MODE_WRAP=0, MODE_SAT=1) and the lane-index width function SHALL live in a shared package, lane_data_pkg.
REQ-022 The round-robin pending-lane selector SHALL be a single sub-module, rr_lane_arbiter, taking the pending vector and last-served index and returning the grant index and any-pending.
REQ-023 Lane update logic SHALL be a generate loop in the top module; no further sub-modules.

Verification
REQ-024 Defaults, mode=0, map=4'b0001, tick held high: lane0 SHALL step 0,4,8,12,16,0; wrap[0] SHALL pulse once, on the cycle after the 16->0 edge.
REQ-025 mode=1, same stimulus: lane0 SHALL reach 16 and stay there; wrap SHALL stay 0; no event SHALL follow the 16 record.
REQ-026 With STEP=5, LIMIT=16: lane values SHALL run 0,5,10,15,16,0.
REQ-027 All four lanes advance in one cycle with out_ready=1: records SHALL appear with out_lane 0,1,2,3 on consecutive cycles, each with out_data=4.
REQ-028 out_ready=0 for 5 cycles while lane2 advances 3 times: out_lane and out_data SHALL hold the first capture; after ready, exactly one further lane-2 record SHALL follow, with out_data=12.
REQ-029 clr[1] and advance on lane 1 in the same cycle: data_1 SHALL become 0 with no wrap; reset asserted with out_valid=1 SHALL give out_valid=0 and all lanes=0 on the next cycle.
